scan_seq6: RTL and testbench

Registered address sequencer that drives the enable and 6-bit select inputs of the 6-to-64 decoder, walking a programmable address window one line at a time. Each line is held for a programmable dwell time, then `en` is blanked for one cycle while the address changes. This break-before-make gap keeps two decoder outputs from ever being active at once. The block runs single-shot or continuously and reports progress with `busy`, `done` and `wrap`.

---
 rtl/scan_pkg.sv | 15 +
 rtl/scan_dwell_cnt.sv | 30 +++
 rtl/scan_seq6.sv | 116 +++++++++++
 tb/tb_scan_seq6.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and sizes for the decoder address sequencer.
// No logic; no latency.
// No flow control.
package scan_pkg;

    localparam int ADDR_W    = 6;
    localparam int NUM_LINES = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BLANK
    } scan_state_t;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Loadable dwell down-counter; zero marks the final active cycle of a line.
// Load takes effect on the next edge.
// No backpressure; decrements only when dec is high.
module scan_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dec,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt;

    // Holds remaining cycles minus one, so a load of 0 behaves like a load of 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val == '0) ? '0 : load_val - DWELL_W'(1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/scan_seq6.sv
// Walks a 6-bit decoder address window with per-line dwell and a one-cycle enable gap.
// Start to first enabled line: 1 cycle; stop to enable low: 1 cycle.
// No backpressure; start is ignored while a scan is running, stop always wins.
module scan_seq6
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [5:0]         first,
    input  logic [5:0]         last,
    input  logic [DWELL_W-1:0] dwell,
    output logic               en,
    output logic [5:0]         A,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    scan_state_t        state;
    logic               cont_q;
    logic [5:0]         first_q;
    logic [5:0]         last_q;
    logic [DWELL_W-1:0] dwell_q;

    logic               cnt_load;
    logic               cnt_zero;
    logic [DWELL_W-1:0] cnt_val;

    // Launch loads the live dwell input; every later line reuses the latched copy.
    assign cnt_load = ((state == IDLE) && start && !stop) || ((state == BLANK) && !stop);
    assign cnt_val  = (state == IDLE) ? dwell : dwell_q;

    scan_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (state == ACTIVE),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            en      <= 1'b0;
            A       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            cont_q  <= 1'b0;
            first_q <= '0;
            last_q  <= '0;
            dwell_q <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        cont_q  <= cont;
                        first_q <= first;
                        last_q  <= last;
                        dwell_q <= dwell;
                        A       <= first;
                        en      <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt_zero) begin
                        en <= 1'b0;
                        if (A != last_q) begin
                            A     <= A + ADDR_W'(1);
                            state <= BLANK;
                        end else if (!cont_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            A     <= first_q;
                            wrap  <= 1'b1;
                            state <= BLANK;
                        end
                    end
                end
                BLANK: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        en    <= 1'b1;
                        state <= ACTIVE;
                    end
                end
                default: begin
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_seq6.sv
// Scoreboard bench for scan_seq6: per-cycle expected outputs are queued at launch
// and compared on the falling edge.
module tb_scan_seq6;

    typedef struct packed {
        logic       en;
        logic [5:0] a;
        logic       busy;
        logic       done;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont_i = 1'b0;
    logic [5:0] first_i = '0;
    logic [5:0] last_i = '0;
    logic [7:0] dwell_i = '0;
    logic       en;
    logic [5:0] a_o;
    logic       busy;
    logic       done;
    logic       wrap;

    exp_t expq[$];
    exp_t seq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cur_a = 0;
    logic pen = 1'b0;
    logic [5:0] pa = '0;

    scan_seq6 #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .cont  (cont_i),
        .first (first_i),
        .last  (last_i),
        .dwell (dwell_i),
        .en    (en),
        .A     (a_o),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic exp_t mk(input bit e, input int a, input bit b, input bit dn, input bit w);
        exp_t r;
        r.en   = e;
        r.a    = a[5:0];
        r.busy = b;
        r.done = dn;
        r.wrap = w;
        return r;
    endfunction

    // Scoreboard pop plus break-before-make watch.
    always @(negedge clk) begin
        if (!rst_n) begin
            pen = 1'b0;
        end else begin
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("en", en, e.en);
                chk("A", a_o, e.a);
                chk("busy", busy, e.busy);
                chk("done", done, e.done);
                chk("wrap", wrap, e.wrap);
            end
            if (pen && en)
                chk("bbm_A_stable", a_o, pa);
            pen = en;
            pa  = a_o;
        end
    end

    // Reference cycle sequence starting with the cycle after the start edge.
    task automatic gen(input int f, input int l, input int d, input int c, input int maxc);
        int a;
        int dd;
        bit fin;
        a   = f;
        dd  = (d == 0) ? 1 : d;
        fin = 1'b0;
        seq.delete();
        while (!fin && seq.size() < maxc) begin
            for (int i = 0; i < dd; i++) seq.push_back(mk(1, a, 1, 0, 0));
            if (a != l) begin
                a = (a + 1) % 64;
                seq.push_back(mk(0, a, 1, 0, 0));
            end else if (c == 0) begin
                seq.push_back(mk(0, a, 0, 1, 0));
                fin = 1'b1;
            end else begin
                a = f;
                seq.push_back(mk(0, a, 1, 0, 1));
            end
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (expq.size() > 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (expq.size() > 0) begin
            chk({tag, "_timeout"}, expq.size(), 0);
            expq.delete();
        end
    endtask

    task automatic run(input int f, input int l, input int d, input int c,
                       input int maxc, input int stop_at, input int bstart_at);
        int fa;
        int last_i_cyc;
        gen(f, l, d, c, maxc);
        if (stop_at >= 0) begin
            while (seq.size() > stop_at + 1) void'(seq.pop_back());
            seq.push_back(mk(0, seq[stop_at].a, 0, 0, 0));
        end
        fa = seq[seq.size()-1].a;
        @(posedge clk); #2;
        expq.push_back(mk(0, cur_a, 0, 0, 0));
        start   = 1'b1;
        cont_i  = c[0];
        first_i = f[5:0];
        last_i  = l[5:0];
        dwell_i = d[7:0];
        foreach (seq[i]) expq.push_back(seq[i]);
        expq.push_back(mk(0, fa, 0, 0, 0));
        expq.push_back(mk(0, fa, 0, 0, 0));
        @(posedge clk); #2;
        start   = 1'b0;
        cont_i  = $urandom_range(0, 1);
        first_i = $urandom_range(0, 63);
        last_i  = $urandom_range(0, 63);
        dwell_i = $urandom_range(0, 255);
        last_i_cyc = (stop_at > bstart_at) ? stop_at : bstart_at;
        for (int i = 0; i <= last_i_cyc; i++) begin
            if (i == stop_at) stop = 1'b1;
            if (i == bstart_at) begin
                start   = 1'b1;
                first_i = 6'd40;
                last_i  = 6'd41;
                dwell_i = 8'd9;
            end
            @(posedge clk); #2;
            stop  = 1'b0;
            start = 1'b0;
        end
        drain("run");
        cur_a = fa;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        // Reset state and quiet idle.
        for (int i = 0; i < 3; i++) expq.push_back(mk(0, 0, 0, 0, 0));
        drain("reset_idle");

        // Single pass 2..4, dwell 3, with a start attempted mid-scan.
        run(2, 4, 3, 0, 1000, -1, 5);
        // Address wrap with dwell 0.
        run(62, 1, 0, 0, 1000, -1, -1);
        // Continuous single line, stopped after a few wraps.
        run(5, 5, 2, 1, 12, 10, -1);
        // Stop during a blank cycle.
        run(10, 12, 2, 0, 1000, 2, -1);

        // start and stop together in idle: nothing happens.
        @(posedge clk); #2;
        start = 1'b1; stop = 1'b1; first_i = 6'd33; dwell_i = 8'd4;
        for (int i = 0; i < 4; i++) expq.push_back(mk(0, cur_a, 0, 0, 0));
        @(posedge clk); #2;
        start = 1'b0; stop = 1'b0;
        drain("start_stop");

        // Asynchronous reset mid-ACTIVE.
        @(posedge clk); #2;
        expq.push_back(mk(0, cur_a, 0, 0, 0));
        start = 1'b1; cont_i = 1'b1; first_i = 6'd20; last_i = 6'd30; dwell_i = 8'd5;
        expq.push_back(mk(1, 20, 1, 0, 0));
        expq.push_back(mk(1, 20, 1, 0, 0));
        @(posedge clk); #2;
        start = 1'b0;
        drain("pre_reset");
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_en", en, 0);
        chk("rst_A", a_o, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cur_a = 0;
        for (int i = 0; i < 4; i++) expq.push_back(mk(0, 0, 0, 0, 0));
        drain("post_reset");

        // Scan still works after a mid-scan reset.
        run(0, 1, 1, 0, 1000, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
